// File: rtl/cache_pkg.sv
// cache_pkg: shared encodings, FSM state and address-split widths for the L1 cache
package cache_pkg;
  localparam logic [1:0] RW_READ = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [2:0] HM_NONE = 3'b000;
  localparam logic [2:0] HM_HIT = 3'b001;
  localparam logic [2:0] HM_MISS = 3'b010;
  localparam logic [2:0] HM_WR = 3'b100;
  typedef enum logic {S_IDLE, S_FILL} state_t;
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int aw, input int sets);
    return aw - $clog2(sets) - 2;
  endfunction
endpackage

// File: rtl/cache_backing_mem.sv
// cache_backing_mem: word-addressed main-memory model, async read, sync write, never reset
module cache_backing_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic [$clog2(MEM_WORDS)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]        o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative write-through/write-allocate L1 data cache
// with blocking read-miss fill from a private backing memory.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS = 64,
  parameter int MISS_LATENCY = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            rw,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            hit_miss,
  output logic                  stall
);
  localparam int IW = idx_w(NUM_SETS);
  localparam int TW = tag_w(ADDR_WIDTH, NUM_SETS);
  localparam int MW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MISS_LATENCY + 1);
  logic [1:0]            r_valid [NUM_SETS];
  logic [TW-1:0]         r_tag   [NUM_SETS][2];
  logic [DATA_WIDTH-1:0] r_data  [NUM_SETS][2];
  logic [NUM_SETS-1:0]   r_lru;
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_fill_idx;
  logic [TW-1:0]         r_fill_tag;
  logic [MW-1:0]         r_fill_word;
  logic [IW-1:0]         w_idx;
  logic [TW-1:0]         w_tag;
  logic [MW-1:0]         w_word;
  logic                  w_hit0, w_hit1, w_hit, w_way, w_wway;
  logic                  w_rd, w_wr, w_miss, w_fill_done;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic                  w_unused;
  assign w_idx = addr[IW+1:2];
  assign w_tag = addr[ADDR_WIDTH-1:IW+2];
  assign w_word = addr[MW+1:2];
  assign w_unused = ^addr[1:0];
  assign w_hit0 = r_valid[w_idx][0] && r_tag[w_idx][0] == w_tag;
  assign w_hit1 = r_valid[w_idx][1] && r_tag[w_idx][1] == w_tag;
  assign w_hit = w_hit0 | w_hit1;
  assign w_way = w_hit1;
  // writes land in the matching way, or allocate the LRU victim on a miss
  assign w_wway = w_hit ? w_way : r_lru[w_idx];
  assign w_rd = !reset && r_state == S_IDLE && rw == RW_READ;
  assign w_wr = !reset && r_state == S_IDLE && rw == RW_WRITE && we;
  assign w_miss = w_rd && !w_hit;
  assign w_fill_done = !reset && r_state == S_FILL && r_cnt == CW'(MISS_LATENCY);
  cache_backing_mem #(.DATA_WIDTH(DATA_WIDTH), .MEM_WORDS(MEM_WORDS)) u_mem (
    .clk    (clk),
    .i_we   (w_wr),
    .i_waddr(w_word),
    .i_wdata(data_in),
    .i_raddr(r_fill_word),
    .o_rdata(w_mem_rdata)
  );
  always_ff @(posedge clk)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == S_IDLE ? (w_miss ? S_FILL : S_IDLE) : (w_fill_done ? S_IDLE : S_FILL);
  always_comb begin
    stall = !reset && (r_state == S_FILL || w_miss);
    hit_miss = reset ? HM_NONE :
               r_state == S_FILL ? HM_MISS :
               w_rd ? (w_hit ? HM_HIT : HM_MISS) :
               w_wr ? (HM_WR | (w_hit ? HM_HIT : HM_MISS)) : HM_NONE;
    data_out = (w_rd && w_hit) ? r_data[w_idx][w_way] : '0;
  end
  always_ff @(posedge clk)
    if (reset) r_cnt <= '0;
    else if (w_miss) r_cnt <= CW'(1);
    else if (r_state == S_FILL) r_cnt <= w_fill_done ? '0 : r_cnt + 1'b1;
  always_ff @(posedge clk)
    if (w_miss) begin
      r_fill_idx <= w_idx;
      r_fill_tag <= w_tag;
      r_fill_word <= w_word;
    end
  always_ff @(posedge clk)
    if (reset) begin
      r_valid <= '{default: '0};
      r_lru <= '0;
    end else if (w_wr) begin
      r_valid[w_idx][w_wway] <= 1'b1;
      r_lru[w_idx] <= !w_wway;
    end else if (w_rd && w_hit) begin
      r_lru[w_idx] <= !w_way;
    end else if (w_fill_done) begin
      r_valid[r_fill_idx][r_lru[r_fill_idx]] <= 1'b1;
      r_lru[r_fill_idx] <= !r_lru[r_fill_idx];
    end
  always_ff @(posedge clk)
    if (w_wr) begin
      r_tag[w_idx][w_wway] <= w_tag;
      r_data[w_idx][w_wway] <= data_in;
    end else if (w_fill_done) begin
      r_tag[r_fill_idx][r_lru[r_fill_idx]] <= r_fill_tag;
      r_data[r_fill_idx][r_lru[r_fill_idx]] <= w_mem_rdata;
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed-vector check of hits, fills, LRU eviction, writes and reset abort
module tb_cache_controller;
  import cache_pkg::*;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [1:0]  rw;
  logic        we;
  logic [31:0] data_out;
  logic [2:0]  hit_miss;
  logic        stall;
  int          total = 0;
  int          bad = 0;
  cache_controller dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .data_in (data_in),
    .rw      (rw),
    .we      (we),
    .data_out(data_out),
    .hit_miss(hit_miss),
    .stall   (stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rw = r;
    we = w;
    addr = a;
    data_in = d;
    #1;
  endtask
  task automatic rd_hit(input string tag, input logic [31:0] a, input logic [31:0] d);
    drive(RW_READ, 1'b0, a, '0);
    chk({tag, "_hm"}, 32'(hit_miss), 32'(HM_HIT));
    chk({tag, "_data"}, data_out, d);
    chk({tag, "_stall"}, 32'(stall), 0);
  endtask
  task automatic rd_fill(input string tag, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    drive(RW_READ, 1'b0, a, '0);
    chk({tag, "_miss_hm"}, 32'(hit_miss), 32'(HM_MISS));
    chk({tag, "_miss_data"}, data_out, 0);
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
      #1;
      if (stall) chk({tag, "_fill_hm"}, 32'(hit_miss), 32'(HM_MISS));
    end
    chk({tag, "_stall_len"}, n, 5);
    chk({tag, "_after_hm"}, 32'(hit_miss), 32'(HM_HIT));
    chk({tag, "_after_data"}, data_out, d);
  endtask
  initial begin
    reset = 1'b1;
    rw = RW_READ;
    we = 1'b0;
    addr = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hm", 32'(hit_miss), 32'(HM_NONE));
    chk("rst_stall", 32'(stall), 0);
    chk("rst_data", data_out, 0);
    @(negedge clk);
    reset = 1'b0;
    rw = 2'b10;
    #1;
    chk("post_rst_hm", 32'(hit_miss), 32'(HM_NONE));
    chk("post_rst_stall", 32'(stall), 0);
    // write-allocate into way0, then hit
    drive(RW_WRITE, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF);
    chk("wr_miss_hm", 32'(hit_miss), 32'(HM_WR | HM_MISS));
    chk("wr_miss_stall", 32'(stall), 0);
    chk("wr_miss_data", data_out, 0);
    rd_hit("rd1", 32'h1000_0000, 32'hDEAD_BEEF);
    // new tag in same set fills way1 from aliased backing word 0
    rd_fill("rd2", 32'h2000_0000, 32'hDEAD_BEEF);
    rd_hit("rd1b", 32'h1000_0000, 32'hDEAD_BEEF);
    rd_hit("rd2b", 32'h2000_0000, 32'hDEAD_BEEF);
    // LRU now way0 (0x1000_0000) -> third tag evicts it
    rd_fill("rd3", 32'h3000_0000, 32'hDEAD_BEEF);
    rd_fill("rd1_evicted", 32'h1000_0000, 32'hDEAD_BEEF);
    drive(RW_WRITE, 1'b1, 32'h1000_0000, 32'h1234_5678);
    chk("wr_hit_hm", 32'(hit_miss), 32'(HM_WR | HM_HIT));
    chk("wr_hit_stall", 32'(stall), 0);
    rd_hit("rd_wr", 32'h1000_0000, 32'h1234_5678);
    drive(2'b10, 1'b1, 32'h1000_0000, 32'hAAAA_5555);
    chk("idle_hm", 32'(hit_miss), 32'(HM_NONE));
    chk("idle_stall", 32'(stall), 0);
    chk("idle_data", data_out, 0);
    drive(RW_WRITE, 1'b0, 32'h1000_0000, 32'hAAAA_5555);
    chk("we0_hm", 32'(hit_miss), 32'(HM_NONE));
    chk("we0_stall", 32'(stall), 0);
    chk("we0_data", data_out, 0);
    rd_hit("rd_unch", 32'h1000_0000, 32'h1234_5678);
    rd_hit("rd_3_old", 32'h3000_0000, 32'hDEAD_BEEF);
    // reset on the 2nd fill cycle aborts the fill and invalidates everything
    drive(RW_READ, 1'b0, 32'h4000_0000, '0);
    chk("abort_miss_stall", 32'(stall), 1);
    @(negedge clk);
    #1;
    chk("abort_fill1_stall", 32'(stall), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rw = 2'b11;
    #1;
    chk("abort_stall", 32'(stall), 0);
    chk("abort_hm", 32'(hit_miss), 32'(HM_NONE));
    rd_fill("rd_after_rst", 32'h1000_0000, 32'h1234_5678);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
